// File: rtl/atm_pkg.sv
// Shared types and codes for the ATM account ledger: op/status encodings,
// FSM states, default widths and the database entry record.
package atm_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int AMT_W_DEF  = 6;

  typedef enum logic [2:0] {
    OP_AUTH     = 3'b000,
    OP_BALANCE  = 3'b001,
    OP_DEPOSIT  = 3'b010,
    OP_WITHDRAW = 3'b011,
    OP_TRANSFER = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'b000,
    ST_NO_ACCT  = 3'b001,
    ST_BAD_PIN  = 3'b010,
    ST_INSUFF   = 3'b011,
    ST_NO_DST   = 3'b100,
    ST_BAD_OP   = 3'b101,
    ST_OVERFLOW = 3'b110,
    ST_LOCKED   = 3'b111
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EXEC,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] acct;
    logic [DATA_W_DEF-1:0] pin;
    logic [DATA_W_DEF-1:0] balance;
  } entry_t;

endpackage

// File: rtl/atm_account_ledger_if.sv
// Request/response channel between the ATM controller (master) and the
// account ledger (slave).
interface atm_account_ledger_if #(
  parameter int DATA_W = 12,
  parameter int AMT_W  = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_acct;
  logic [DATA_W-1:0] req_pin;
  logic [DATA_W-1:0] req_dst;
  logic [AMT_W-1:0]  req_amount;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_status;
  logic [DATA_W-1:0] rsp_balance;
  logic [DATA_W-1:0] rsp_dst_balance;

  modport master (
    output req_valid, req_op, req_acct, req_pin, req_dst, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
  );

  modport slave (
    input  req_valid, req_op, req_acct, req_pin, req_dst, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
  );
endinterface

// File: rtl/atm_entry_file.sv
// Account database storage: init load port, one registered read port for the
// scan, and two balance commit ports (source and destination of a transfer).
module atm_entry_file #(
  parameter int NUM_ACCTS = 4,
  parameter int DATA_W    = 12,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_we,
  input  logic [IDX_W-1:0]  init_idx,
  input  logic [DATA_W-1:0] init_acct,
  input  logic [DATA_W-1:0] init_pin,
  input  logic [DATA_W-1:0] init_balance,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_acct,
  output logic [DATA_W-1:0] rd_pin,
  output logic [DATA_W-1:0] rd_balance,
  input  logic              wa_en,
  input  logic [IDX_W-1:0]  wa_idx,
  input  logic [DATA_W-1:0] wa_balance,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_balance
);

  typedef struct packed {
    logic [DATA_W-1:0] acct;
    logic [DATA_W-1:0] pin;
    logic [DATA_W-1:0] balance;
  } ent_t;

  ent_t mem [NUM_ACCTS];
  ent_t rd_q;

  // NOTE: the database must come up empty, so every entry sits on the async reset;
  // this forces flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) mem[i] <= '0;
      rd_q <= '0;
    end else begin
      if (init_we && int'(init_idx) < NUM_ACCTS)
        mem[init_idx] <= '{acct: init_acct, pin: init_pin, balance: init_balance};
      if (wa_en) mem[wa_idx].balance <= wa_balance;
      if (wb_en) mem[wb_idx].balance <= wb_balance;
      rd_q <= (int'(rd_idx) < NUM_ACCTS) ? mem[rd_idx] : '0;
    end
  end

  assign rd_acct    = rd_q.acct;
  assign rd_pin     = rd_q.pin;
  assign rd_balance = rd_q.balance;

endmodule

// File: rtl/atm_account_ledger.sv
// Bank-side ATM ledger: scans the account database, authorises and commits one
// request at a time. Optional per-account PIN lockout under ACCT_LOCKOUT_EN.
module atm_account_ledger
  import atm_pkg::*;
#(
  parameter  int NUM_ACCTS = 4,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int AMT_W     = AMT_W_DEF,
  parameter  int MAX_TRIES = 3,
  localparam int IDX_W     = $clog2(NUM_ACCTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_account_ledger_if.slave  bus,
  input  logic                 init_we,
  input  logic [IDX_W-1:0]     init_idx,
  input  logic [DATA_W-1:0]    init_acct,
  input  logic [DATA_W-1:0]    init_pin,
  input  logic [DATA_W-1:0]    init_balance
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);

  state_e             state;
  logic [IDX_W-1:0]   iss_idx, cmp_idx;
  logic               primed;
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  acct_q, pin_q, dst_q;
  logic [AMT_W-1:0]   amt_q;
  logic               src_found, dst_found;
  logic [IDX_W-1:0]   src_idx, dst_idx;
  logic [DATA_W-1:0]  src_pin, src_bal, dst_bal;
  logic [DATA_W-1:0]  rd_acct, rd_pin, rd_balance;

  logic               exec_st, init_en;
  status_e            status_n;
  logic [DATA_W-1:0]  bal_n, dst_n, wa_bal, wb_bal;
  logic               wa_en, wb_en, pin_bad, pin_good, locked;
  logic [DATA_W:0]    amt_w, src_sum, dst_sum;

  assign exec_st       = (state == S_EXEC);
  assign init_en       = init_we && (state == S_IDLE);
  assign bus.req_ready = !rst && (state == S_IDLE) && !init_we;

  atm_entry_file #(.NUM_ACCTS(NUM_ACCTS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_entries (
    .clk, .rst,
    .init_we(init_en), .init_idx, .init_acct, .init_pin, .init_balance,
    .rd_idx(iss_idx), .rd_acct, .rd_pin, .rd_balance,
    .wa_en(wa_en && exec_st), .wa_idx(src_idx), .wa_balance(wa_bal),
    .wb_en(wb_en && exec_st), .wb_idx(dst_idx), .wb_balance(wb_bal)
  );

`ifdef ACCT_LOCKOUT_EN
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  logic [CNT_W-1:0] fail_cnt [NUM_ACCTS];

  assign locked = (fail_cnt[src_idx] == CNT_W'(MAX_TRIES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) fail_cnt[i] <= '0;
    end else if (init_en) begin
      fail_cnt[init_idx] <= '0;
    end else if (exec_st) begin
      if (pin_bad && fail_cnt[src_idx] != CNT_W'(MAX_TRIES))
        fail_cnt[src_idx] <= fail_cnt[src_idx] + 1'b1;
      else if (pin_good)
        fail_cnt[src_idx] <= '0;
    end
  end
`else
  logic unused_lockout;
  assign locked         = 1'b0;
  assign unused_lockout = (MAX_TRIES != 0) ^ pin_bad ^ pin_good;
`endif

  assign amt_w   = (DATA_W+1)'(amt_q);
  assign src_sum = {1'b0, src_bal} + amt_w;
  assign dst_sum = {1'b0, dst_bal} + amt_w;

  // NOTE: every output gets a default up front so no path leaves one unassigned (no latches).
  always_comb begin
    status_n = ST_OK;
    bal_n    = src_found ? src_bal : '0;
    dst_n    = '0;
    wa_en    = 1'b0;
    wa_bal   = src_bal;
    wb_en    = 1'b0;
    wb_bal   = dst_bal;
    pin_bad  = 1'b0;
    pin_good = 1'b0;
    if (op_q > OP_TRANSFER) begin
      status_n = ST_BAD_OP;
    end else if (!src_found) begin
      status_n = ST_NO_ACCT;
    end else if (locked) begin
      status_n = ST_LOCKED;
    end else if (pin_q != src_pin) begin
      status_n = ST_BAD_PIN;
      pin_bad  = 1'b1;
    end else begin
      pin_good = 1'b1;
      case (op_q)
        OP_DEPOSIT: begin
          if (src_sum[DATA_W]) status_n = ST_OVERFLOW;
          else begin
            wa_en  = 1'b1;
            wa_bal = src_sum[DATA_W-1:0];
            bal_n  = src_sum[DATA_W-1:0];
          end
        end
        OP_WITHDRAW: begin
          if (amt_w > {1'b0, src_bal}) status_n = ST_INSUFF;
          else begin
            wa_en  = 1'b1;
            wa_bal = src_bal - amt_w[DATA_W-1:0];
            bal_n  = src_bal - amt_w[DATA_W-1:0];
          end
        end
        OP_TRANSFER: begin
          if (!dst_found) begin
            status_n = ST_NO_DST;
          end else if (dst_idx == src_idx) begin
            // Self-transfer nets to zero: report success and touch nothing.
            dst_n = src_bal;
          end else if (amt_w > {1'b0, src_bal}) begin
            status_n = ST_INSUFF;
            dst_n    = dst_bal;
          end else if (dst_sum[DATA_W]) begin
            status_n = ST_OVERFLOW;
            dst_n    = dst_bal;
          end else begin
            wa_en  = 1'b1;
            wa_bal = src_bal - amt_w[DATA_W-1:0];
            bal_n  = src_bal - amt_w[DATA_W-1:0];
            wb_en  = 1'b1;
            wb_bal = dst_sum[DATA_W-1:0];
            dst_n  = dst_sum[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state here uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      iss_idx             <= '0;
      cmp_idx             <= '0;
      primed              <= 1'b0;
      op_q                <= '0;
      acct_q              <= '0;
      pin_q               <= '0;
      dst_q               <= '0;
      amt_q               <= '0;
      src_found           <= 1'b0;
      dst_found           <= 1'b0;
      src_idx             <= '0;
      dst_idx             <= '0;
      src_pin             <= '0;
      src_bal             <= '0;
      dst_bal             <= '0;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_status      <= '0;
      bus.rsp_balance     <= '0;
      bus.rsp_dst_balance <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q      <= bus.req_op;
            acct_q    <= bus.req_acct;
            pin_q     <= bus.req_pin;
            dst_q     <= bus.req_dst;
            amt_q     <= bus.req_amount;
            iss_idx   <= '0;
            cmp_idx   <= '0;
            primed    <= 1'b0;
            src_found <= 1'b0;
            dst_found <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // The read port is registered, so comparisons trail the issued index by one.
          primed <= 1'b1;
          if (iss_idx != LAST_IDX) iss_idx <= iss_idx + 1'b1;
          if (primed) begin
            if (rd_acct != '0 && !src_found && rd_acct == acct_q) begin
              src_found <= 1'b1;
              src_idx   <= cmp_idx;
              src_pin   <= rd_pin;
              src_bal   <= rd_balance;
            end
            if (rd_acct != '0 && !dst_found && rd_acct == dst_q) begin
              dst_found <= 1'b1;
              dst_idx   <= cmp_idx;
              dst_bal   <= rd_balance;
            end
            if (cmp_idx == LAST_IDX) state   <= S_EXEC;
            else                     cmp_idx <= cmp_idx + 1'b1;
          end
        end
        S_EXEC: begin
          bus.rsp_valid       <= 1'b1;
          bus.rsp_status      <= status_n;
          bus.rsp_balance     <= bal_n;
          bus.rsp_dst_balance <= dst_n;
          state               <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_ledger.sv
// Directed self-checking bench for atm_account_ledger (NUM_ACCTS=4); the
// lockout scenario runs only when ACCT_LOCKOUT_EN is defined.
module tb_atm_account_ledger;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_we = 1'b0;
  logic [1:0]  init_idx = '0;
  logic [11:0] init_acct = '0, init_pin = '0, init_balance = '0;
  int          total = 0;
  int          bad = 0;

  atm_account_ledger_if #(.DATA_W(12), .AMT_W(6)) bus ();

  atm_account_ledger #(.NUM_ACCTS(4), .DATA_W(12), .AMT_W(6), .MAX_TRIES(3)) dut (
    .clk, .rst, .bus(bus.slave),
    .init_we, .init_idx, .init_acct, .init_pin, .init_balance
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] idx, input entry_t e);
    @(negedge clk);
    init_we = 1'b1; init_idx = idx;
    init_acct = e.acct; init_pin = e.pin; init_balance = e.balance;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic xact(input string tag, input logic [2:0] op, input logic [11:0] acct,
                      input logic [11:0] pin, input logic [11:0] dst, input logic [5:0] amt,
                      input logic [2:0] exp_st, input logic [11:0] exp_bal,
                      input logic [11:0] exp_dst, input bit chk_dst, input int hold);
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_acct = acct;
    bus.req_pin = pin; bus.req_dst = dst; bus.req_amount = amt;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd6);
    check({tag, "_st"}, 32'(bus.rsp_status), 32'(exp_st));
    check({tag, "_bal"}, 32'(bus.rsp_balance), 32'(exp_bal));
    if (chk_dst) check({tag, "_dst"}, 32'(bus.rsp_dst_balance), 32'(exp_dst));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_bal"}, 32'(bus.rsp_balance), 32'(exp_bal));
      check({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_acct = '0; bus.req_pin = '0;
    bus.req_dst = '0; bus.req_amount = '0; bus.rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_status", 32'(bus.rsp_status), 32'd0);
    check("rst_balance", 32'(bus.rsp_balance), 32'd0);
    check("rst_dst_bal", 32'(bus.rsp_dst_balance), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    load(2'd0, '{acct: 12'h123, pin: 12'h111, balance: 12'h050});
    load(2'd1, '{acct: 12'h456, pin: 12'h222, balance: 12'h010});

    xact("bal",      3'b001, 12'h123, 12'h111, 12'h000, 6'h00, ST_OK,      12'h050, 12'h000, 1, 0);
    xact("xfer",     3'b100, 12'h123, 12'h111, 12'h456, 6'h20, ST_OK,      12'h030, 12'h030, 1, 0);
    xact("bal_dst",  3'b001, 12'h456, 12'h222, 12'h000, 6'h00, ST_OK,      12'h030, 12'h000, 1, 0);
    xact("no_dst",   3'b100, 12'h123, 12'h111, 12'h789, 6'h01, ST_NO_DST,  12'h030, 12'h000, 1, 0);
    xact("bad_op",   3'b111, 12'h123, 12'h111, 12'h000, 6'h01, ST_BAD_OP,  12'h030, 12'h000, 1, 0);

    load(2'd0, '{acct: 12'h123, pin: 12'h111, balance: 12'h050});
    load(2'd1, '{acct: 12'h456, pin: 12'h222, balance: 12'h010});
    xact("wd_insuff", 3'b011, 12'h456, 12'h222, 12'h000, 6'h11, ST_INSUFF, 12'h010, 12'h000, 0, 0);
    xact("wd_exact",  3'b011, 12'h456, 12'h222, 12'h000, 6'h10, ST_OK,     12'h000, 12'h000, 0, 0);
    xact("dep",       3'b010, 12'h123, 12'h111, 12'h000, 6'h0F, ST_OK,     12'h05F, 12'h000, 1, 0);

    load(2'd2, '{acct: 12'h789, pin: 12'h333, balance: 12'hFF0});
    xact("dep_ovf",   3'b010, 12'h789, 12'h333, 12'h000, 6'h20, ST_OVERFLOW, 12'hFF0, 12'h000, 0, 0);
    xact("dep_max",   3'b010, 12'h789, 12'h333, 12'h000, 6'h0F, ST_OK,       12'hFFF, 12'h000, 0, 0);
    xact("bal_max",   3'b001, 12'h789, 12'h333, 12'h000, 6'h00, ST_OK,       12'hFFF, 12'h000, 0, 0);
    xact("bad_pin",   3'b000, 12'h123, 12'h000, 12'h000, 6'h00, ST_BAD_PIN,  12'h05F, 12'h000, 0, 0);
    xact("acct_zero", 3'b001, 12'h000, 12'h000, 12'h000, 6'h00, ST_NO_ACCT,  12'h000, 12'h000, 0, 0);
    xact("no_acct",   3'b001, 12'h999, 12'h111, 12'h000, 6'h00, ST_NO_ACCT,  12'h000, 12'h000, 0, 0);
    xact("wd_zero",   3'b011, 12'h123, 12'h111, 12'h000, 6'h00, ST_OK,       12'h05F, 12'h000, 0, 0);
    xact("xfer_self", 3'b100, 12'h123, 12'h111, 12'h123, 6'h05, ST_OK,       12'h05F, 12'h05F, 1, 0);
    xact("xfer_ins",  3'b100, 12'h456, 12'h222, 12'h123, 6'h01, ST_INSUFF,   12'h000, 12'h000, 0, 0);
    xact("xfer_ovf",  3'b100, 12'h123, 12'h111, 12'h789, 6'h01, ST_OVERFLOW, 12'h05F, 12'h000, 0, 0);
    xact("bal_after", 3'b001, 12'h123, 12'h111, 12'h000, 6'h00, ST_OK,       12'h05F, 12'h000, 0, 0);
    xact("hold",      3'b001, 12'h789, 12'h333, 12'h000, 6'h00, ST_OK,       12'hFFF, 12'h000, 1, 5);

`ifdef ACCT_LOCKOUT_EN
    for (int i = 0; i < 3; i++)
      xact("lk_bad", 3'b000, 12'h123, 12'h000, 12'h000, 6'h00, ST_BAD_PIN, 12'h05F, 12'h000, 0, 0);
    xact("lk_locked", 3'b000, 12'h123, 12'h111, 12'h000, 6'h00, ST_LOCKED, 12'h05F, 12'h000, 0, 0);
    load(2'd0, '{acct: 12'h123, pin: 12'h111, balance: 12'h050});
    xact("lk_reload", 3'b000, 12'h123, 12'h111, 12'h000, 6'h00, ST_OK,     12'h050, 12'h000, 0, 0);
`endif

    // Leave a non-zero response behind so the reset below visibly clears it.
    xact("pre_rst",   3'b110, 12'h789, 12'h333, 12'h000, 6'h01, ST_BAD_OP, 12'hFFF, 12'h000, 0, 0);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'b010; bus.req_acct = 12'h789;
    bus.req_pin = 12'h333; bus.req_amount = 6'h01;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_status", 32'(bus.rsp_status), 32'd0);
    check("midrst_bal", 32'(bus.rsp_balance), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact("cleared_789", 3'b001, 12'h789, 12'h333, 12'h000, 6'h00, ST_NO_ACCT, 12'h000, 12'h000, 0, 0);
    xact("cleared_123", 3'b001, 12'h123, 12'h111, 12'h000, 6'h00, ST_NO_ACCT, 12'h000, 12'h000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_account_ledger.md
Name: atm_account_ledger

Overview:
- Bank-side responder for the ATM controller. Holds the account database (account number, PIN, balance) in registers.
- Services one request at a time over a valid/ready request channel and returns status plus balances on a valid/ready response channel.
- Replaces file-based database access: the ATM issues operations, and this block authorises and commits them.

Parameters:
- NUM_ACCTS, 4, number of database entries (min 2).
- DATA_W, 12, width of account number, PIN and balance.
- AMT_W, 6, width of request amount.
- MAX_TRIES, 3, consecutive bad PINs before lockout (used only with ACCT_LOCKOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  000 AUTH, 001 BALANCE, 010 DEPOSIT, 011 WITHDRAW, 100 TRANSFER.
- req_acct  in  DATA_W  source account number.
- req_pin  in  DATA_W  PIN for the source account.
- req_dst  in  DATA_W  destination account (TRANSFER only).
- req_amount  in  AMT_W  amount (DEPOSIT/WITHDRAW/TRANSFER).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_status  out  3  000 OK, 001 NO_ACCT, 010 BAD_PIN, 011 INSUFF, 100 NO_DST, 101 BAD_OP, 110 OVERFLOW, 111 LOCKED.
- rsp_balance  out  DATA_W  source balance after the operation.
- rsp_dst_balance  out  DATA_W  destination balance after TRANSFER, else 0.
- init_we  in  1  database load strobe.
- init_idx  in  clog2(NUM_ACCTS)  entry to load.
- init_acct, init_pin, init_balance  in  DATA_W each  entry contents.

Behaviour:
- Reset:
  - State IDLE; all entries cleared to 0.
  - req_ready=0 during reset, then 1 in IDLE.
  - rsp_valid=0; rsp_status, rsp_balance and rsp_dst_balance all 0.
- Empty entries: account number 0 marks an empty entry and never matches. req_acct=0 returns NO_ACCT.
- req_ready = (state==IDLE) && !init_we. init_we is honoured only in IDLE and is ignored in other states.
- FSM:
  - IDLE: on req_valid&&req_ready, latch all req_* fields and go to SCAN. The index counter clears.
  - SCAN: visit one entry per cycle, index 0..NUM_ACCTS-1.
    - Record the first entry whose number equals the source, and separately the first that equals the destination.
    - After index NUM_ACCTS-1, go to EXEC.
  - EXEC: one cycle. Evaluate in this order:
    1. Invalid op → BAD_OP.
    2. Source not found → NO_ACCT.
    3. PIN mismatch → BAD_PIN.
    4. Op-specific checks (below).
    - Commit writes only on OK, then go to RESP.
  - RESP: hold rsp_valid=1 and the response fields stable until rsp_ready, then return to IDLE.
- Latency: with acceptance on edge T, rsp_valid rises on edge T+NUM_ACCTS+2. No back-to-back acceptance: the next request can be accepted at the earliest on the edge after the response handshake.
- Operations:
  - AUTH, BALANCE: no write. Return the source balance.
  - DEPOSIT: sum computed at DATA_W+1 bits. If sum > 2^DATA_W-1 → OVERFLOW and no write; else write the sum.
  - WITHDRAW: if amount > balance → INSUFF and no write; amount == balance is allowed, leaving balance 0.
  - TRANSFER:
    - Destination not found → NO_DST.
    - amount > source balance → INSUFF.
    - Destination sum overflow → OVERFLOW.
    - Otherwise debit the source and credit the destination in the same cycle.
    - dst == src: OK with balance unchanged.
  - Amount 0: OK, balances unchanged.
- Failure responses: rsp_balance reports the current (unchanged) source balance when the source is found, else 0.
- Reset mid-operation aborts the request: no commit, rsp_valid drops immediately.

Optional Feature:
- ACCT_LOCKOUT_EN defined:
  - Per-entry fail counter, clog2(MAX_TRIES+1) bits, reset 0.
  - Each BAD_PIN increments the counter, saturating at MAX_TRIES. A correct PIN clears it. init_we to an entry clears it.
  - When counter==MAX_TRIES, every op on that source returns LOCKED (checked after NO_ACCT, before PIN). The counter is not changed.
- ACCT_LOCKOUT_EN undefined: no counters, LOCKED is never produced, and MAX_TRIES is unused.

Decomposition:
- Shared package atm_pkg: op code constants, status code constants, DATA_W/AMT_W defaults, entry struct typedef {acct, pin, balance}.
- One sub-module, atm_entry_file: entry storage, init write port, indexed read mux, and the commit write port (two writes per cycle for TRANSFER). The FSM and arithmetic stay in the top.

Test Plan:
- Load {0x123,0x111,0x050}, {0x456,0x222,0x010}; BALANCE 0x123/0x111 → OK, balance 0x050; rsp_valid on the 6th edge after accept with NUM_ACCTS=4.
- DEPOSIT 0x123 amount 0x0F → OK 0x05F; DEPOSIT to a balance of 0xFF0 with amount 0x20 → OVERFLOW, balance stays 0xFF0.
- WITHDRAW 0x456 amount 0x11 → INSUFF, balance 0x010; amount 0x10 → OK, balance 0x000.
- TRANSFER 0x123→0x456 amount 0x20 from balances 0x050/0x010 → OK, rsp_balance 0x030, rsp_dst_balance 0x030; dst 0x789 → NO_DST; op 111 → BAD_OP.
- Hold rsp_ready=0 for 5 cycles → response stable, req_ready=0. Assert rst during SCAN → no commit, rsp_valid=0, all entries 0.
- With ACCT_LOCKOUT_EN: three AUTH to 0x123 with PIN 0x000 → BAD_PIN ×3; fourth with PIN 0x111 → LOCKED; init_we reload of that entry → AUTH OK.
